// File: rtl/v_sync_detect.sv
// Recovers the vertical line number from asynchronous active-low h/v sync and locks after LOCK_FRAMES good frames.
// Define V_SYNC_DETECT_PULSE_CHECK_EN to also require the v_sync pulse to span exactly V_SYNC_PULSE lines.
module v_sync_detect #(
  parameter logic [9:0] AV_Y          = 10'd480,
  parameter logic [1:0] V_SYNC_PULSE  = 2'd2,
  parameter logic [3:0] V_FRONT_PORCH = 4'd10,
  parameter logic [4:0] V_BACK_PORCH  = 5'd29,
  parameter logic [1:0] LOCK_FRAMES   = 2'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       line_valid,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [9:0] Y_TOTAL   = AV_Y + 10'(V_SYNC_PULSE) + 10'(V_FRONT_PORCH) + 10'(V_BACK_PORCH);
  localparam logic [9:0] SYNC_LINE = AV_Y + 10'(V_FRONT_PORCH);
  localparam logic [9:0] Y_LAST    = Y_TOTAL - 10'd1;
  localparam logic [9:0] Y_OVER    = Y_TOTAL + 10'd1;

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_good_cnt, w_good_cnt_nxt;
  logic       r_hs_meta, r_hs_sync, r_hs_prev;
  logic       r_vs_meta, r_vs_sync, r_vs_prev;
  logic [9:0] r_y, r_meas;
  logic       r_frame_start;
  logic       w_line_tick, w_frame_tick, w_frame_ok, w_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs_meta <= 1'b0;
      r_hs_sync <= 1'b0;
      r_hs_prev <= 1'b0;
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_hs_meta <= h_sync;
      r_hs_sync <= r_hs_meta;
      r_hs_prev <= r_hs_sync;
      r_vs_meta <= v_sync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_line_tick  = r_hs_prev & ~r_hs_sync;
  assign w_frame_tick = r_vs_prev & ~r_vs_sync;

  // A frame tick wins over a coincident line tick: the line is absorbed into SYNC_LINE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y           <= 10'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_line_tick && !w_frame_tick && (r_y == Y_LAST) && (r_state == LOCKED);
      if (w_frame_tick) begin
        r_y <= SYNC_LINE;
      end else if (w_line_tick) begin
        r_y <= (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meas <= 10'd0;
    end else if (w_frame_tick) begin
      r_meas <= 10'd0;
    end else if (w_line_tick && (r_meas != 10'h3FF)) begin
      r_meas <= r_meas + 10'd1;
    end
  end

`ifdef V_SYNC_DETECT_PULSE_CHECK_EN
  logic [3:0] r_vs_width;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_width <= 4'd0;
    end else if (w_frame_tick) begin
      r_vs_width <= 4'd0;
    end else if (w_line_tick && !r_vs_sync && (r_vs_width != 4'hF)) begin
      r_vs_width <= r_vs_width + 4'd1;
    end
  end

  assign w_frame_ok = (r_meas == Y_TOTAL) && (r_vs_width == 4'(V_SYNC_PULSE));
`else
  assign w_frame_ok = (r_meas == Y_TOTAL);
`endif

  // Missing v_sync shows up as the measurement running one line past a full frame.
  assign w_overrun = (r_meas == Y_OVER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= SEARCH;
      r_good_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    case (r_state)
      SEARCH: begin
        if (w_frame_tick) begin
          w_state_nxt    = ACQUIRE;
          w_good_cnt_nxt = 2'd0;
        end
      end
      ACQUIRE: begin
        if (w_frame_tick) begin
          if (w_frame_ok) begin
            w_good_cnt_nxt = r_good_cnt + 2'd1;
            if ((r_good_cnt + 2'd1) == LOCK_FRAMES) w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = SEARCH;
          end
        end else if (w_overrun) begin
          w_state_nxt = SEARCH;
        end
      end
      LOCKED: begin
        if (w_frame_tick ? !w_frame_ok : w_overrun) w_state_nxt = SEARCH;
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked     = (r_state == LOCKED);
    line_valid = (r_state == LOCKED) && (r_y < AV_Y);
    sync_err   = 1'b0;
    if (r_state != SEARCH) sync_err = w_frame_tick ? !w_frame_ok : w_overrun;
  end

  assign y           = r_y;
  assign frame_start = r_frame_start;

endmodule
